// File: rtl/tdm_demux_1to8_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_pkg
//  Description : Shared defaults and state encoding for the 1:8 TDM
//                demultiplexer (slot count, slot counter width, FSM states).
//  Revision    : 1.0  initial release
// ============================================================================
package tdm_demux_pkg;

    localparam int TDM_SLOTS  = 8;
    localparam int TDM_SLOT_W = $clog2(TDM_SLOTS);

    // HUNT: waiting for frame_sync.  RUN: locked, collecting slots.
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : tdm_demux_pkg
`default_nettype wire

// File: rtl/tdm_demux_1to8_if.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_1to8_if
//  Description : Serial-in / frame-out bundle of the TDM demultiplexer.
//                master : stream source and frame consumer (drives in_*,
//                         frame_sync, out_ready)
//                slave  : demultiplexer (drives out, out_valid, slot,
//                         overrun, sync_err)
//  Revision    : 1.0  initial release
// ============================================================================
interface tdm_demux_1to8_if
    import tdm_demux_pkg::*;
#(
    parameter int SLOTS  = TDM_SLOTS,
    parameter int SLOT_W = TDM_SLOT_W
);
    logic              in_bit;
    logic              in_valid;
    logic              frame_sync;
    logic [SLOTS-1:0]  out;
    logic              out_valid;
    logic              out_ready;
    logic [SLOT_W-1:0] slot;
    logic              overrun;
    logic              sync_err;

    modport master (
        output in_bit, in_valid, frame_sync, out_ready,
        input  out, out_valid, slot, overrun, sync_err
    );

    modport slave (
        input  in_bit, in_valid, frame_sync, out_ready,
        output out, out_valid, slot, overrun, sync_err
    );
endinterface : tdm_demux_1to8_if
`default_nettype wire

// File: rtl/tdm_demux_1to8_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_slot_counter
//  Description : Registered mod-SLOTS slot counter.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                i_inc     - advance one slot (wraps SLOTS-1 -> 0)
//                i_clr1    - restart: next slot is 1 (slot 0 just taken)
//                i_clr0    - force back to slot 0
//                o_count   - current slot index
//                o_last    - o_count == SLOTS-1
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_slot_counter
    import tdm_demux_pkg::*;
#(
    parameter int SLOTS  = TDM_SLOTS,
    parameter int SLOT_W = TDM_SLOT_W
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_inc,
    input  wire logic              i_clr1,
    input  wire logic              i_clr0,
    output logic      [SLOT_W-1:0] o_count,
    output logic                   o_last
);
    localparam logic [SLOT_W-1:0] c_last_slot = SLOT_W'(SLOTS - 1);

    logic [SLOT_W-1:0] r_count_q;
    logic [SLOT_W-1:0] w_count_d;

    // Clear-to-0 dominates clear-to-1, which dominates increment.
    always_comb begin
        w_count_d = r_count_q;
        if (i_clr0) begin
            w_count_d = '0;
        end else if (i_clr1) begin
            w_count_d = SLOT_W'(1);
        end else if (i_inc) begin
            w_count_d = (r_count_q == c_last_slot) ? '0 : r_count_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign o_count = r_count_q;
    assign o_last  = (r_count_q == c_last_slot);

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux_1to8.sv
`default_nettype none
// ============================================================================
//  Module      : tdm_demux_1to8
//  Description : Time-division demultiplexer. Serial bit k of a frame (slot 0
//                marked by frame_sync) lands in out[k]; completed frames are
//                held on a valid/ready output register.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                bus (slave)   - in_bit/in_valid/frame_sync stream in,
//                                out/out_valid/out_ready frame out,
//                                slot index, overrun and sync_err pulses
//  Revision    : 1.0  initial release
// ============================================================================
module tdm_demux_1to8
    import tdm_demux_pkg::*;
#(
    parameter int SLOTS  = TDM_SLOTS,
    parameter int SLOT_W = TDM_SLOT_W
) (
    input  wire logic          clk,
    input  wire logic          rst,
    tdm_demux_1to8_if.slave    bus
);
    state_t            r_state_q,     w_state_d;
    // Only slots 0..SLOTS-2 need storage; the last bit goes straight to out.
    logic [SLOTS-2:0]  r_shadow_q,    w_shadow_d;
    logic [SLOTS-1:0]  r_out_q,       w_out_d;
    logic              r_out_valid_q, w_out_valid_d;
    logic              r_overrun_q,   w_overrun_d;
    logic              r_sync_err_q,  w_sync_err_d;

    logic              w_cnt_inc;
    logic              w_cnt_clr1;
    logic              w_cnt_clr0;
    logic [SLOT_W-1:0] w_slot;
    logic              w_last;
    logic              w_complete;
    logic              w_consume;

    tdm_slot_counter #(
        .SLOTS  (SLOTS),
        .SLOT_W (SLOT_W)
    ) u_slot_counter (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_cnt_inc),
        .i_clr1  (w_cnt_clr1),
        .i_clr0  (w_cnt_clr0),
        .o_count (w_slot),
        .o_last  (w_last)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_shadow_d    = r_shadow_q;
        w_out_d       = r_out_q;
        w_out_valid_d = r_out_valid_q;
        w_overrun_d   = 1'b0;
        w_sync_err_d  = 1'b0;
        w_cnt_inc     = 1'b0;
        w_cnt_clr1    = 1'b0;
        w_cnt_clr0    = 1'b0;
        w_complete    = 1'b0;
        w_consume     = r_out_valid_q & bus.out_ready;

        if (bus.in_valid) begin
            case (r_state_q)
                HUNT: begin
                    if (bus.frame_sync) begin
                        w_shadow_d    = '0;
                        w_shadow_d[0] = bus.in_bit;
                        w_cnt_clr1    = 1'b1;
                        w_state_d     = RUN;
                    end
                end
                RUN: begin
                    if (bus.frame_sync) begin
                        // A sync mid-frame restarts the frame on this bit.
                        w_sync_err_d  = (w_slot != '0);
                        w_shadow_d    = '0;
                        w_shadow_d[0] = bus.in_bit;
                        w_cnt_clr1    = 1'b1;
                    end else if (w_slot == '0) begin
                        // Expected a sync here: lock is lost.
                        w_sync_err_d  = 1'b1;
                        w_cnt_clr0    = 1'b1;
                        w_state_d     = HUNT;
                    end else if (w_last) begin
                        w_complete    = 1'b1;
                        w_cnt_inc     = 1'b1;
                    end else begin
                        w_shadow_d[w_slot] = bus.in_bit;
                        w_cnt_inc          = 1'b1;
                    end
                end
                default: begin
                    w_state_d = HUNT;
                end
            endcase
        end

        // A full register that is not being drained keeps its word; the
        // freshly completed frame is the one that is lost.
        if (w_complete) begin
            if (!r_out_valid_q || w_consume) begin
                w_out_d       = {bus.in_bit, r_shadow_q};
                w_out_valid_d = 1'b1;
            end else begin
                w_overrun_d   = 1'b1;
            end
        end else if (w_consume) begin
            w_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= HUNT;
            r_shadow_q    <= '0;
            r_out_q       <= '0;
            r_out_valid_q <= 1'b0;
            r_overrun_q   <= 1'b0;
            r_sync_err_q  <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_shadow_q    <= w_shadow_d;
            r_out_q       <= w_out_d;
            r_out_valid_q <= w_out_valid_d;
            r_overrun_q   <= w_overrun_d;
            r_sync_err_q  <= w_sync_err_d;
        end
    end

    assign bus.out       = r_out_q;
    assign bus.out_valid = r_out_valid_q;
    assign bus.slot      = w_slot;
    assign bus.overrun   = r_overrun_q;
    assign bus.sync_err  = r_sync_err_q;

endmodule : tdm_demux_1to8
`default_nettype wire

// File: tb/tb_tdm_demux_1to8.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdm_demux_1to8
//  Description : Self-checking bench for tdm_demux_1to8. A frame-level model
//                (bit queue per frame, occupancy flag for the output word)
//                predicts every edge; consumed words are checked through a
//                scoreboard queue by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tdm_demux_1to8;
    import tdm_demux_pkg::*;

    localparam int N = TDM_SLOTS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_demux_1to8_if bus ();

    tdm_demux_1to8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (reflects the DUT after the most recent edge)
    bit           m_locked;
    bit           m_bits[$];
    bit           m_full;
    logic [N-1:0] m_word_reg;
    bit           exp_overrun;
    bit           exp_sync_err;
    logic [N-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_edge(input bit v, input bit fs, input bit b, input bit rdy, input bit r);
        bit           consumed;
        bit           done;
        logic [N-1:0] w;
        w = '0;
        done = 1'b0;
        if (r) begin
            m_locked = 1'b0;
            m_bits.delete();
            m_full = 1'b0;
            m_word_reg = '0;
            exp_q.delete();
            exp_overrun = 1'b0;
            exp_sync_err = 1'b0;
            return;
        end
        exp_overrun = 1'b0;
        exp_sync_err = 1'b0;
        consumed = m_full && rdy;
        if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_bits.delete();
                    m_bits.push_back(b);
                    m_locked = 1'b1;
                end
            end else if (fs) begin
                if (m_bits.size() != 0) exp_sync_err = 1'b1;
                m_bits.delete();
                m_bits.push_back(b);
            end else if (m_bits.size() == 0) begin
                exp_sync_err = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_bits.push_back(b);
                if (m_bits.size() == N) begin
                    for (int k = 0; k < N; k++) w[k] = m_bits[k];
                    done = 1'b1;
                    m_bits.delete();
                end
            end
        end
        if (done) begin
            if (!m_full || consumed) begin
                m_word_reg = w;
                m_full = 1'b1;
                exp_q.push_back(w);
            end else begin
                exp_overrun = 1'b1;
            end
        end else if (consumed) begin
            m_full = 1'b0;
        end
    endtask

    // One clock: model the edge with the inputs now applied, then drive the
    // inputs for the following edge.
    task automatic step(input bit v, input bit fs, input bit b, input bit rdy, input bit r = 1'b0);
        @(posedge clk);
        model_edge(bus.in_valid, bus.frame_sync, bus.in_bit, bus.out_ready, rst);
        #1;
        bus.in_valid   = v;
        bus.frame_sync = fs;
        bus.in_bit     = b;
        bus.out_ready  = r ? 1'b0 : rdy;
        rst            = r;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), rdy);
    endtask

    task automatic send_frame(input logic [N-1:0] word, input bit rdy, input int gap_max);
        for (int k = 0; k < N; k++) begin
            idle(int'($urandom_range(0, gap_max)), rdy);
            step(1'b1, k == 0, word[k], rdy);
        end
    endtask

    // Monitor: per-cycle outputs against the model, consumed words against
    // the scoreboard queue.
    initial begin : monitor
        logic [N-1:0] w;
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("slot",      32'(bus.slot),      32'(m_bits.size()));
            check("out_valid", 32'(bus.out_valid), 32'(m_full));
            check("out",       32'(bus.out),       32'(m_word_reg));
            check("overrun",   32'(bus.overrun),   32'(exp_overrun));
            check("sync_err",  32'(bus.sync_err),  32'(exp_sync_err));
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL word: got %0h, expected no word at t=%0t", bus.out, $time);
                end else begin
                    w = exp_q.pop_front();
                    check("word", 32'(bus.out), 32'(w));
                end
            end
        end
    end

    initial begin : stimulus
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        bus.in_bit     = 1'b0;
        bus.out_ready  = 1'b0;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        idle(2, 0);

        // Basic frame, bits 1,0,1,1,0,0,1,0 in slots 0..7
        send_frame(8'b0100_1101, 1'b1, 0);
        idle(3, 1'b1);

        // Back-to-back frames with the consumer stalled: second frame overruns
        send_frame(8'hA5, 1'b0, 0);
        send_frame(8'h3C, 1'b0, 0);
        idle(2, 1'b0);
        step(0, 0, 0, 1);
        idle(3, 1'b0);

        // frame_sync re-asserted at slot 4
        step(1, 1, 0, 1);
        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        send_frame(8'hFF, 1'b1, 0);
        idle(2, 1'b1);

        // Missing sync at slot 0 drops lock; unsynced beats are ignored
        step(1, 0, 1, 1);
        step(1, 0, 1, 1);
        step(1, 0, 0, 1);
        step(1, 0, 1, 1);
        send_frame(8'h33, 1'b1, 0);
        idle(2, 1'b1);

        // Random in_valid gaps inside a frame
        send_frame(8'h81, 1'b1, 5);
        idle(2, 1'b1);

        // Reset at slot 5, then a clean frame
        step(1, 1, 1, 1);
        for (int k = 1; k < 5; k++) step(1, 0, 1'($urandom), 1);
        step(0, 0, 0, 0, 1);
        idle(2, 1'b1);
        send_frame(8'h5A, 1'b1, 0);
        idle(2, 1'b1);

        // Randomized traffic: mostly well-formed, with stray/missing syncs,
        // gaps, consumer stalls and occasional reset
        for (int i = 0; i < 1500; i++) begin
            bit v;
            bit fs;
            bit rdy;
            bit r;
            v   = ($urandom % 4) != 0;
            fs  = ((m_bits.size() == 0) && (($urandom % 10) != 0)) || (($urandom % 20) == 0);
            rdy = ($urandom % 3) != 0;
            r   = ($urandom % 300) == 0;
            step(v, fs, 1'($urandom), rdy, r);
        end

        // Drain whatever is still held
        idle(12, 1'b1);
        @(negedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_tdm_demux_1to8
`default_nettype wire
